// File: rtl/collision_status_ctrl.sv
// Game-status controller: bird/obstacle overlap detection, lives with post-hit
// grace frames, saturating score and the IDLE/PLAY/HIT/OVER sequence.
module collision_status_ctrl #(
  parameter int NUM_OBST   = 2,
  parameter int LIVES      = 3,
  parameter int LIVES_W    = 2,
  parameter int SCORE_W    = 8,
  parameter int HIT_FRAMES = 60
) (
  input  logic                clk,
  input  logic                Reset,
  input  logic                FrameTick,
  input  logic                PixelValid,
  input  logic                R_Bird_off,
  input  logic [NUM_OBST-1:0] R_Obst_off,
  input  logic [NUM_OBST-1:0] PassPulse,
  input  logic                Start,
  output logic                Status,
  output logic [1:0]          State,
  output logic [LIVES_W-1:0]  Lives,
  output logic [SCORE_W-1:0]  Score,
  output logic                HitPulse,
  output logic                GameOver
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_HIT  = 2'd2,
    ST_OVER = 2'd3
  } state_t;

  localparam int CNT_W = $clog2(NUM_OBST + 1);
  localparam int SUM_W = ((SCORE_W > CNT_W) ? SCORE_W : CNT_W) + 1;
  localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(LIVES);
  localparam logic [7:0]         GRACE_INIT = 8'(HIT_FRAMES);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = {SCORE_W{1'b1}};

  state_t               state_q, state_d;
  logic [LIVES_W-1:0]   lives_q, lives_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [7:0]           grace_q, grace_d;
  logic                 hit_pulse_q, hit_pulse_d;
  logic                 status_q, status_d;
  logic                 game_over_q, game_over_d;

  logic                 overlap;
  logic [CNT_W-1:0]     pass_cnt [NUM_OBST+1];
  logic [SUM_W-1:0]     score_sum;
  logic [SCORE_W-1:0]   score_sat;

  // Several obstacles overlapping in one pixel still count as one overlap.
  assign overlap = PixelValid & R_Bird_off & (|R_Obst_off);

  // Ripple popcount of the pass pulses.
  assign pass_cnt[0] = '0;
  generate
    for (genvar gi = 0; gi < NUM_OBST; gi++) begin : g_pass_cnt
      assign pass_cnt[gi+1] = pass_cnt[gi] + CNT_W'(PassPulse[gi]);
    end
  endgenerate

  assign score_sum = SUM_W'(score_q) + SUM_W'(pass_cnt[NUM_OBST]);
  assign score_sat = (score_sum > SUM_W'(SCORE_MAX)) ? SCORE_MAX : score_sum[SCORE_W-1:0];

  always_comb begin
    state_d     = state_q;
    lives_d     = lives_q;
    score_d     = score_q;
    grace_d     = grace_q;
    hit_pulse_d = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_OVER: begin
        if (Start) begin
          state_d = ST_PLAY;
          lives_d = LIVES_INIT;
          score_d = '0;
        end
      end
      ST_PLAY: begin
        score_d = score_sat;
        if (overlap) begin
          hit_pulse_d = 1'b1;
          if (lives_q > LIVES_W'(1)) begin
            lives_d = lives_q - LIVES_W'(1);
            grace_d = GRACE_INIT;
            state_d = ST_HIT;
          end else begin
            lives_d = '0;
            state_d = ST_OVER;
          end
        end
      end
      ST_HIT: begin
        score_d = score_sat;
        if (FrameTick) begin
          // A zero count can only be reached by the final tick; treat it as expiry too.
          if (grace_q <= 8'd1) begin
            grace_d = 8'd0;
            state_d = ST_PLAY;
          end else begin
            grace_d = grace_q - 8'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    status_d    = (state_d != ST_OVER);
    game_over_d = (state_d == ST_OVER);
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      lives_q     <= LIVES_INIT;
      score_q     <= '0;
      grace_q     <= 8'd0;
      hit_pulse_q <= 1'b0;
      status_q    <= 1'b1;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lives_q     <= lives_d;
      score_q     <= score_d;
      grace_q     <= grace_d;
      hit_pulse_q <= hit_pulse_d;
      status_q    <= status_d;
      game_over_q <= game_over_d;
    end
  end

  assign State    = state_q;
  assign Lives    = lives_q;
  assign Score    = score_q;
  assign HitPulse = hit_pulse_q;
  assign Status   = status_q;
  assign GameOver = game_over_q;

endmodule
